pe_lsu_responder: RTL

Memory-side responder for the per-PE load/store path of the CGRA. It accepts one LOAD or STR request from a processing element and runs it on a TCDM-style bank port with req/gnt/r_valid handshakes. It returns a one-cycle data_req_valid_o pulse with load_data_o, which is exactly what the PE ALU consumes as data_req_valid_i/load_data_i. It stalls the PE through busy_o while the access is in flight.

---
 rtl/cgra_lsu_pkg.sv | 21 ++
 rtl/lsu_timeout_cnt.sv | 34 +++
 rtl/pe_lsu_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cgra_lsu_pkg.sv
// Shared types and constants for the CGRA per-PE load/store responder.
// Opcode constants document the upstream decode that produces lsu_req_i.
package cgra_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [5:0]  OPC_LOAD = 6'b000111;
  localparam logic [5:0]  OPC_STR  = 6'b001001;
  localparam int          MAX_BE_W = 64;
  localparam logic [63:0] BE_ALL   = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/lsu_timeout_cnt.sv
// Cycle counter bounding how long a bank access may stay outstanding.
// expire is asserted in the enabled cycle where the count reaches TIMEOUT-1.
module lsu_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int             CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // count cycles while the access is outstanding, restart whenever idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = enable && (cnt_r == LAST);

endmodule

// File: rtl/pe_lsu_responder.sv
// Memory-side responder: runs one PE LOAD/STR on a TCDM bank port and
// returns a single-cycle data_req_valid_o pulse, stalling the PE meanwhile.
module pe_lsu_responder
  import cgra_lsu_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Exec_En_Global,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [AWIDTH-1:0]   lsu_addr_i,
  input  logic [DWIDTH-1:0]   lsu_wdata_i,
  output logic                busy_o,
  output logic                data_req_valid_o,
  output logic [DWIDTH-1:0]   load_data_o,
  output logic                err_o,
  output logic                tcdm_req_o,
  input  logic                tcdm_gnt_i,
  output logic [AWIDTH-1:0]   tcdm_add_o,
  output logic                tcdm_we_o,
  output logic [DWIDTH/8-1:0] tcdm_be_o,
  output logic [DWIDTH-1:0]   tcdm_wdata_o,
  input  logic                tcdm_r_valid_i,
  input  logic [DWIDTH-1:0]   tcdm_r_rdata_i
);

  localparam int BEW = DWIDTH / 8;

  lsu_state_t         state_r, state_s;
  logic               mis_r, mis_s;
  logic               busy_s, valid_s, err_s, req_s, we_s;
  logic [DWIDTH-1:0]  load_s, wdata_s;
  logic [AWIDTH-1:0]  add_s;
  logic               expire_s;

  lsu_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (state_r == IDLE),
    .enable ((state_r == REQ) || (state_r == WAIT)),
    .expire (expire_s)
  );

  // next-state and next-output computation
  always_comb begin
    state_s = state_r;
    mis_s   = mis_r;
    busy_s  = busy_o;
    valid_s = 1'b0;
    load_s  = load_data_o;
    err_s   = err_o;
    req_s   = tcdm_req_o;
    add_s   = tcdm_add_o;
    we_s    = tcdm_we_o;
    wdata_s = tcdm_wdata_o;
    case (state_r)
      IDLE: begin
        if (lsu_req_i && Exec_En_Global) begin
          busy_s = 1'b1;
          if (is_aligned(lsu_addr_i[1:0])) begin
            mis_s   = 1'b0;
            req_s   = 1'b1;
            add_s   = lsu_addr_i;
            we_s    = lsu_we_i;
            wdata_s = lsu_wdata_i;
            state_s = REQ;
          end else begin
            // misaligned access stalls for one WAIT cycle without touching the bank
            mis_s   = 1'b1;
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (expire_s) begin
          req_s   = 1'b0;
          busy_s  = 1'b0;
          valid_s = 1'b1;
          load_s  = '0;
          err_s   = 1'b1;
          state_s = RESP;
        end else if (tcdm_gnt_i) begin
          req_s   = 1'b0;
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mis_r) begin
          busy_s  = 1'b0;
          valid_s = 1'b1;
          load_s  = '0;
          err_s   = 1'b1;
          state_s = RESP;
        end else if (tcdm_r_valid_i) begin
          busy_s  = 1'b0;
          valid_s = 1'b1;
          load_s  = tcdm_we_o ? '0 : tcdm_r_rdata_i;
          state_s = RESP;
        end else if (expire_s) begin
          busy_s  = 1'b0;
          valid_s = 1'b1;
          load_s  = '0;
          err_s   = 1'b1;
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        req_s   = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r          <= IDLE;
      mis_r            <= 1'b0;
      busy_o           <= 1'b0;
      data_req_valid_o <= 1'b0;
      load_data_o      <= '0;
      err_o            <= 1'b0;
      tcdm_req_o       <= 1'b0;
      tcdm_add_o       <= '0;
      tcdm_we_o        <= 1'b0;
      tcdm_be_o        <= '0;
      tcdm_wdata_o     <= '0;
    end else begin
      state_r          <= state_s;
      mis_r            <= mis_s;
      busy_o           <= busy_s;
      data_req_valid_o <= valid_s;
      load_data_o      <= load_s;
      err_o            <= err_s;
      tcdm_req_o       <= req_s;
      tcdm_add_o       <= add_s;
      tcdm_we_o        <= we_s;
      tcdm_be_o        <= BE_ALL[BEW-1:0];
      tcdm_wdata_o     <= wdata_s;
    end
  end

endmodule
